conv3x3_filter: RTL and testbench

//  Downstream of the 3x3 window reader. Takes nine 8-bit window pixels per cycle and convolves them with a

---
 rtl/conv3x3_filter.sv | 149 ++++++++++++++
 tb/tb_conv3x3_filter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_filter.sv
// 3x3 convolution stage: signed programmable kernel, shift-normalise, saturate to 8 bits, frame counter.
// Optional build macro CONV3X3_ABS_EN: output the magnitude of negative results instead of clamping to 0.
module conv3x3_filter #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 32,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        p1,
  input  logic [7:0]        p2,
  input  logic [7:0]        p3,
  input  logic [7:0]        p4,
  input  logic [7:0]        p5,
  input  logic [7:0]        p6,
  input  logic [7:0]        p7,
  input  logic [7:0]        p8,
  input  logic [7:0]        p9,
  input  logic              coef_wr,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [7:0]        pixel_out,
  output logic              wr,
  output logic              frame_done,
  output logic              busy,
  output logic              coef_err
);

  localparam int PW   = 9 + COEF_W;
  localparam int SW   = PW + 4;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0]              LAST    = CW'(NPIX - 1);
  localparam logic signed [COEF_W-1:0]   K_ID    = COEF_W'(1 << SHIFT);
  localparam logic signed [SW-1:0]       SAT_MAX = SW'(32'sd255);

  logic [7:0]               pix_s [9];
  logic signed [COEF_W-1:0] k_q [9];
  logic signed [PW-1:0]     prod_q [9];
  logic signed [SW-1:0]     row_q [3];
  logic                     v1_q, v2_q;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [7:0]               pix_q, pix_d;
  logic                     wr_q, fd_q, fd_d, busy_q, busy_d, err_q, err_d;
  logic                     coef_ok_s;
  logic signed [SW-1:0]     total_s, sh_s, mag_s;
  logic [7:0]               sat_s;

  assign pix_s[0] = p1;
  assign pix_s[1] = p2;
  assign pix_s[2] = p3;
  assign pix_s[3] = p4;
  assign pix_s[4] = p5;
  assign pix_s[5] = p6;
  assign pix_s[6] = p7;
  assign pix_s[7] = p8;
  assign pix_s[8] = p9;

  // Kernel may only change with the pipeline empty, so a frame never mixes kernels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) k_q[i] <= (i == 4) ? K_ID : '0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (coef_ok_s && (coef_addr == 4'(i))) k_q[i] <= coef_data;
      end
    end
  end

  // S1 products and S2 row sums; the data path is reset so wr cleanly drops mid-stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      for (int r = 0; r < 3; r++) row_q[r] <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      for (int i = 0; i < 9; i++) prod_q[i] <= PW'($signed({1'b0, pix_s[i]})) * PW'(k_q[i]);
      for (int r = 0; r < 3; r++) begin
        row_q[r] <= SW'(prod_q[3*r]) + SW'(prod_q[3*r+1]) + SW'(prod_q[3*r+2]);
      end
      v1_q <= in_valid;
      v2_q <= v1_q;
    end
  end

  // S3 arithmetic: total, arithmetic shift, optional magnitude, saturation.
  always_comb begin
    total_s = row_q[0] + row_q[1] + row_q[2];
    sh_s    = total_s >>> SHIFT;
    mag_s   = sh_s;
`ifdef CONV3X3_ABS_EN
    if (sh_s[SW-1]) mag_s = -sh_s;
    else            mag_s = sh_s;
`endif
    if (mag_s[SW-1])           sat_s = 8'd0;
    else if (mag_s > SAT_MAX)  sat_s = 8'hFF;
    else                       sat_s = mag_s[7:0];
  end

  // Next-state for outputs, frame counter and coefficient write arbitration.
  always_comb begin
    cnt_d = cnt_q;
    fd_d  = 1'b0;
    if (v2_q) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        fd_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        fd_d  = 1'b0;
      end
    end else begin
      cnt_d = cnt_q;
    end
    pix_d     = v2_q ? sat_s : 8'd0;
    busy_d    = (cnt_d != '0) | in_valid | v1_q | v2_q;
    coef_ok_s = coef_wr & ~busy_q & ~in_valid & (coef_addr < 4'd9);
    err_d     = coef_wr & (busy_q | in_valid);
  end

  // Output and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pix_q  <= 8'd0;
      wr_q   <= 1'b0;
      fd_q   <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pix_q  <= pix_d;
      wr_q   <= v2_q;
      fd_q   <= fd_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign pixel_out  = pix_q;
  assign wr         = wr_q;
  assign frame_done = fd_q;
  assign busy       = busy_q;
  assign coef_err   = err_q;

endmodule

// File: tb/tb_conv3x3_filter.sv
// Directed self-checking bench for conv3x3_filter (default 256x32 frame, SHIFT=4).
module tb_conv3x3_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic       coef_wr;
  logic [3:0] coef_addr;
  logic [7:0] coef_data;
  logic [7:0] pixel_out;
  logic       wr, frame_done, busy, coef_err;

  int n_chk  = 0;
  int n_pass = 0;
  localparam int NPIX = 8192;

  conv3x3_filter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .pixel_out(pixel_out), .wr(wr), .frame_done(frame_done), .busy(busy), .coef_err(coef_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input logic [7:0] other, input logic [7:0] center);
    {p1, p2, p3, p4, p6, p7, p8, p9} = {8{other}};
    p5 = center;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_coef(input logic [3:0] a, input logic [7:0] d, output logic err);
    coef_wr = 1'b1; coef_addr = a; coef_data = d;
    tick();
    coef_wr = 1'b0;
    err = coef_err;
  endtask

  task automatic load_kernel(input logic [7:0] k [9], output logic any_err);
    logic e;
    any_err = 1'b0;
    for (int i = 0; i < 9; i++) begin
      write_coef(4'(i), k[i], e);
      any_err = any_err | e;
    end
  endtask

  // One isolated window: wr must appear exactly on the third edge.
  task automatic single(input string tag, input logic [7:0] other, input logic [7:0] center, input int exp);
    set_win(other, center);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_lat"}, int'(wr), 0);
    tick();
    chk({tag, "_wr"}, int'(wr), 1);
    chk(tag, int'(pixel_out), exp);
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  // Full frame of consecutive windows under the identity kernel (pixel_out must equal p5).
  task automatic stream(input string tag, input int n, input int err_at);
    int wrs = 0, gaps = 0, pixbad = 0, fds = 0, fd_idx = -1, errs = 0;
    int busy_fd = -1, busy_after = -1;
    logic fd_prev = 1'b0;
    for (int c = 0; c < n + 3; c++) begin
      in_valid  = (c < n);
      set_win(8'd200, pat(c));
      coef_wr   = (c == err_at);
      coef_addr = 4'd4;
      coef_data = 8'd32;
      tick();
      if (int'(wr) != int'((c >= 2) && (c - 2 < n))) gaps++;
      if (wr) begin
        if (pixel_out != pat(wrs)) pixbad++;
        wrs++;
      end
      if (fd_prev) busy_after = int'(busy);
      fd_prev = frame_done;
      if (frame_done) begin
        fds++;
        fd_idx  = wrs - 1;
        busy_fd = int'(busy);
      end
      if (coef_err) errs++;
    end
    in_valid = 1'b0;
    coef_wr  = 1'b0;
    chk({tag, "_wr_count"}, wrs, n);
    chk({tag, "_wr_gaps"}, gaps, 0);
    chk({tag, "_pixel_errs"}, pixbad, 0);
    chk({tag, "_fd_count"}, fds, 1);
    chk({tag, "_fd_index"}, fd_idx, n - 1);
    chk({tag, "_busy_at_fd"}, busy_fd, 1);
    chk({tag, "_busy_after_fd"}, busy_after, 0);
    chk({tag, "_coef_err_count"}, errs, (err_at >= 0) ? 1 : 0);
  endtask

  initial begin
    logic       e;
    logic [7:0] kern [9];
    int         wr_seen;
    rst = 1'b1; in_valid = 1'b0; coef_wr = 1'b0; coef_addr = 4'd0; coef_data = 8'd0;
    set_win(8'd0, 8'd0);
    tick();
    tick();
    chk("rst_pixel", int'(pixel_out), 0);
    chk("rst_wr", int'(wr), 0);
    chk("rst_fd", int'(frame_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_coef_err", int'(coef_err), 0);
    rst = 1'b0;
    tick();

    // Identity kernel from reset; the partial frame keeps busy high and blocks writes.
    single("identity", 8'd200, 8'd77, 77);
    chk("busy_partial_frame", int'(busy), 1);
    write_coef(4'd4, 8'd5, e);
    chk("coef_err_busy", int'(e), 1);
    do_reset();

    for (int i = 0; i < 9; i++) kern[i] = 8'd1;
    load_kernel(kern, e);
    chk("load_ones_err", int'(e), 0);
    single("ones", 8'd100, 8'd100, 56);
    do_reset();

    for (int i = 0; i < 9; i++) kern[i] = 8'd16;
    load_kernel(kern, e);
    single("saturate", 8'd255, 8'd255, 255);
    do_reset();

    write_coef(4'd9, 8'd5, e);
    chk("addr9_no_err", int'(e), 0);
    write_coef(4'd15, 8'd5, e);
    chk("addr15_no_err", int'(e), 0);
    for (int i = 0; i < 9; i++) kern[i] = 8'hFF;
    kern[4] = 8'd8;
    load_kernel(kern, e);
    // Write alongside in_valid must be rejected and must not disturb this window.
    set_win(8'd50, 8'd0);
    in_valid = 1'b1; coef_wr = 1'b1; coef_addr = 4'd4; coef_data = 8'd0;
    tick();
    in_valid = 1'b0; coef_wr = 1'b0;
    chk("coef_err_in_valid", int'(coef_err), 1);
    tick();
    tick();
    chk("laplacian_wr", int'(wr), 1);
`ifdef CONV3X3_ABS_EN
    chk("laplacian", int'(pixel_out), 25);
`else
    chk("laplacian", int'(pixel_out), 0);
`endif
    do_reset();

    stream("frame1", NPIX, 4000);
    write_coef(4'd4, 8'd32, e);
    chk("coef_after_frame_err", int'(e), 0);
    single("k5_32", 8'd200, 8'd10, 20);

    // Fill S1..S3 then reset asynchronously between edges.
    set_win(8'd0, 8'd9);
    in_valid = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_wr", int'(wr), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_wr", int'(wr), 0);
    chk("async_rst_pixel", int'(pixel_out), 0);
    chk("async_rst_busy", int'(busy), 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    wr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wr) wr_seen++;
    end
    chk("post_rst_no_wr", wr_seen, 0);
    stream("frame2", NPIX, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
